// File: rtl/slm_bank_ctrl.sv
// Front-end for a 1W/1R shared-local-memory bank: write/read valid/ready channels,
// byte-enable to bit-mask expansion, write-wins collision handling, ordered response FIFO.
module slm_bank_ctrl #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 64,
    parameter bit SCRUB_EN  = 1'b1,
    parameter int RSP_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_valid,
    output logic                rd_ready,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                init_done,
    output logic                CE0,
    output logic [ADDR_W-1:0]   A0,
    output logic [DATA_W-1:0]   D0,
    output logic                WE0,
    output logic [DATA_W-1:0]   WEM0,
    output logic                CE1,
    output logic [ADDR_W-1:0]   A1,
    input  logic [DATA_W-1:0]   Q1
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RSP_DEPTH);
    localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(RSP_DEPTH);

    typedef enum logic {
        ST_SCRUB,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = SCRUB_EN ? ST_SCRUB : ST_RUN;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   scrub_cnt_q;
    logic                scrub_last;

    logic                wr_active;
    logic                hazard;
    logic                credit_ok;
    logic                rd_fire;
    logic [DATA_W-1:0]   be_mask;

    logic                inflight_q;
    logic                push;
    logic                pop;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W:0]      credit_used;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_MAX) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign scrub_last = (scrub_cnt_q == {ADDR_W{1'b1}});

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_SCRUB && scrub_last) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            scrub_cnt_q <= '0;
        end else if (state_q == ST_SCRUB) begin
            scrub_cnt_q <= scrub_cnt_q + ADDR_W'(1);
        end
    end

    always_comb begin
        be_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            be_mask[i*8 +: 8] = {8{wr_be[i]}};
        end
    end

    // A zero-byte-enable write never touches the bank, so it cannot collide with a read.
    assign wr_active   = wr_valid && (wr_be != '0);
    assign hazard      = wr_active && (wr_addr == rd_addr);
    assign pop         = (count_q != '0) && rsp_ready;
    assign push        = inflight_q;
    assign credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    assign credit_ok   = (credit_used < CREDIT_LIM);
    assign rd_fire     = RSTN && (state_q == ST_RUN) && rd_valid && credit_ok && !hazard;

    // NOTE: every output gets a default first, so no latch is inferred; gating on RSTN
    // keeps the bank ports idle while reset is held, even though the state is combinationally decoded.
    always_comb begin
        wr_ready  = 1'b0;
        rd_ready  = 1'b0;
        init_done = 1'b0;
        CE0       = 1'b0;
        WE0       = 1'b0;
        A0        = '0;
        D0        = '0;
        WEM0      = '0;
        CE1       = 1'b0;
        A1        = '0;
        if (RSTN) begin
            case (state_q)
                ST_SCRUB: begin
                    CE0  = 1'b1;
                    WE0  = 1'b1;
                    A0   = scrub_cnt_q;
                    WEM0 = '1;
                end
                ST_RUN: begin
                    wr_ready  = 1'b1;
                    rd_ready  = credit_ok && !hazard;
                    init_done = 1'b1;
                    if (wr_active) begin
                        CE0  = 1'b1;
                        WE0  = 1'b1;
                        A0   = wr_addr;
                        D0   = wr_data;
                        WEM0 = be_mask;
                    end
                    if (rd_fire) begin
                        CE1 = 1'b1;
                        A1  = rd_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            assert (!(push && !pop && count_q == CNT_FULL));
            inflight_q <= rd_fire;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; its contents are only visible through rsp_valid-masked rsp_data.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= Q1;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_slm_bank_ctrl.sv
// Bench for slm_bank_ctrl: bank model plus a transaction-level memory/response reference,
// directed steps followed by a randomized phase and a mid-traffic reset.
module tb_slm_bank_ctrl;

    localparam int AW        = 4;
    localparam int DW        = 64;
    localparam int DEPTH     = 2;
    localparam int SCRUB_CYC = 1 << AW;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [AW-1:0] wr_addr, rd_addr, A0, A1;
    logic [DW-1:0] wr_data, rsp_data, D0, WEM0, Q1;
    logic [7:0]    wr_be;
    logic          rsp_valid, rsp_ready, init_done, CE0, WE0, CE1;

    logic [DW-1:0] bank [SCRUB_CYC];
    logic [DW-1:0] q1_r = '0;
    bit            seeded = 1'b0;

    logic [DW-1:0] ref_mem [SCRUB_CYC];
    rsp_t          exp_q [$];
    int            cyc;
    int            checks = 0;
    int            failures = 0;
    bit            last_rd_acc;

    slm_bank_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SCRUB_EN(1'b1), .RSP_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
        .CE1(CE1), .A1(A1), .Q1(Q1)
    );

    always #5 CLK = ~CLK;

    // Bank: bit-masked write port, registered read port; starts with garbage so the scrub matters.
    always @(posedge CLK) begin
        if (!seeded) begin
            for (int i = 0; i < SCRUB_CYC; i++) bank[i] <= {$urandom, $urandom};
            seeded <= 1'b1;
        end else begin
            if (CE0 && WE0) bank[A0] <= (bank[A0] & ~WEM0) | (D0 & WEM0);
            if (CE1) q1_r <= bank[A1];
        end
    end
    assign Q1 = q1_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [7:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] be_bits(input logic [7:0] be);
        logic [DW-1:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // One clock: check outputs at the falling edge against the model, then advance the model.
    task automatic cycle();
        bit init_exp, hz, vis, pop, rd_rdy_exp, rd_hs;
        logic [DW-1:0] rdat;
        @(negedge CLK);
        init_exp = (cyc >= SCRUB_CYC);
        check("init_done", 64'(init_done), 64'(init_exp));
        check("wr_ready", 64'(wr_ready), 64'(init_exp));
        last_rd_acc = 1'b0;
        if (!init_exp) begin
            check("scrub_ce0", 64'({CE0, WE0}), 64'd3);
            check("scrub_a0", 64'(A0), 64'(cyc));
            check("scrub_d0", D0, 64'd0);
            check("scrub_wem", WEM0, {64{1'b1}});
            check("scrub_rd", 64'({rd_ready, CE1}), 64'd0);
        end else begin
            hz         = wr_valid && (wr_be != 8'h00) && (wr_addr == rd_addr);
            vis        = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            pop        = vis && rsp_ready;
            rd_rdy_exp = ((exp_q.size() - int'(pop)) < DEPTH) && !hz;
            rd_hs      = rd_valid && rd_rdy_exp;
            check("rd_ready", 64'(rd_ready), 64'(rd_rdy_exp));
            check("rsp_valid", 64'(rsp_valid), 64'(vis));
            if (vis) check("rsp_data", rsp_data, exp_q[0].data);
            if (wr_valid && wr_be != 8'h00) begin
                check("wr_ce_we", 64'({CE0, WE0}), 64'd3);
                check("wr_a0", 64'(A0), 64'(wr_addr));
                check("wr_d0", D0, wr_data);
                check("wr_wem", WEM0, be_bits(wr_be));
            end else begin
                check("wr_idle_ce0", 64'({CE0, WE0}), 64'd0);
            end
            check("rd_ce1", 64'(CE1), 64'(rd_hs));
            if (rd_hs) check("rd_a1", 64'(A1), 64'(rd_addr));
            rdat = ref_mem[rd_addr];
            if (pop) void'(exp_q.pop_front());
            if (rd_hs) exp_q.push_back('{data: rdat, due: cyc + 2});
            if (wr_valid && wr_be != 8'h00) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
            last_rd_acc = rd_hs;
        end
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] be);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        bit acc = 1'b0;
        rd_valid = 1'b1; rd_addr = a;
        for (int i = 0; i < 20 && !acc; i++) begin
            cycle();
            acc = last_rd_acc;
        end
        rd_valid = 1'b0;
        check("rd_accept_bound", 64'(acc), 64'd1);
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        cyc  = 0;
        for (int i = 0; i < SCRUB_CYC; i++) ref_mem[i] = '0;
        exp_q.delete();
    endtask

    initial begin
        RSTN = 1'b0; cyc = 0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b1;
        #2;
        check("rst_outputs", 64'({init_done, rsp_valid, wr_ready, rd_ready, CE0, WE0, CE1}), 64'd0);
        check("rst_buses", 64'({A0, A1}) | D0 | WEM0 | rsp_data, 64'd0);
        repeat (3) @(posedge CLK);

        // Scrub with junk writes and reads presented: neither may leak through.
        wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 64'hDEAD_BEEF_0000_1111; wr_be = 8'hFF;
        rd_valid = 1'b1; rd_addr = 4'h7;
        release_reset();
        idle(SCRUB_CYC);
        wr_valid = 1'b0; rd_valid = 1'b0;

        do_read(4'd9);
        idle(3);

        do_write(4'hD, 64'h0123_4567_89AB_CDEF, 8'hFF);
        do_read(4'hD);
        idle(3);
        do_write(4'hD, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        do_read(4'hD);
        idle(3);
        check("partial_ref", ref_mem[4'hD], 64'h0123_4567_FFFF_FFFF);

        // Same-address write and read: write wins, read follows one cycle later.
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 64'hAA; wr_be = 8'hFF;
        rd_valid = 1'b1; rd_addr = 4'd5;
        cycle();
        check("collide_stall", 64'(last_rd_acc), 64'd0);
        wr_valid = 1'b0;
        cycle();
        check("collide_issue", 64'(last_rd_acc), 64'd1);
        rd_valid = 1'b0;
        idle(3);
        wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 64'h55; wr_be = 8'h00;
        rd_valid = 1'b1; rd_addr = 4'd5;
        cycle();
        check("be0_no_stall", 64'(last_rd_acc), 64'd1);
        wr_valid = 1'b0; rd_valid = 1'b0;
        idle(3);

        // Back-pressure: only DEPTH reads may be outstanding while the consumer stalls.
        for (int i = 1; i <= 4; i++) do_write(AW'(i), 64'h1111_0000 * i, 8'hFF);
        rsp_ready = 1'b0;
        do_read(4'd1);
        do_read(4'd2);
        rd_valid = 1'b1; rd_addr = 4'd3;
        idle(5);
        check("bp_outstanding", 64'(exp_q.size()), 64'(DEPTH));
        rsp_ready = 1'b1;
        do_read(4'd3);
        do_read(4'd4);
        idle(5);

        // Streaming reads at one per cycle while the consumer keeps up.
        rd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = AW'(i);
            cycle();
            check("stream_accept", 64'(last_rd_acc), 64'd1);
        end
        rd_valid = 1'b0;
        idle(4);

        for (int i = 0; i < 400; i++) begin
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom_range(0, SCRUB_CYC - 1));
            wr_data   = {$urandom, $urandom};
            wr_be     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, SCRUB_CYC - 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        idle(6);

        // Reset with one response queued and one read in flight.
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 4'd1;
        cycle();
        rd_addr = 4'd2;
        cycle();
        rd_valid = 1'b0;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        wr_valid = 1'b1; wr_addr = 4'd6; wr_be = 8'hFF; rd_valid = 1'b1; rd_addr = 4'd7;
        RSTN = 1'b0;
        #1;
        check("mid_rst_rsp", 64'({rsp_valid, init_done, wr_ready, rd_ready}), 64'd0);
        check("mid_rst_bank", 64'({CE0, WE0, CE1}), 64'd0);
        check("mid_rst_data", rsp_data, 64'd0);
        repeat (2) @(posedge CLK);
        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        release_reset();
        idle(SCRUB_CYC + 8);
        do_read(4'd6);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
